// File: rtl/jtframe_edge_pkg.sv
// Shared edge-mode encodings and the priority helper for the edge-capture IRQ bank.
package jtframe_edge_pkg;

    localparam logic [1:0] EDGE_RISE  = 2'b00;
    localparam logic [1:0] EDGE_FALL  = 2'b01;
    localparam logic [1:0] EDGE_BOTH  = 2'b10;
    localparam logic [1:0] EDGE_LEVEL = 2'b11;

    localparam int unsigned MAX_CH = 32;
    localparam int unsigned ID_W   = 5;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [ID_W-1:0] lowest_set(input logic [MAX_CH-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (v[i]) idx = ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/jtframe_edge_det.sv
// One-bit event detector: optional 2-flop synchronizer, persistence filter and edge/level decode.
module jtframe_edge_det
    import jtframe_edge_pkg::*;
#(
    parameter logic [1:0]  MODE = EDGE_RISE,
    parameter int unsigned SYNC = 1,
    parameter int unsigned FILT = 0
)(
    input  logic clk,
    input  logic rst,
    input  logic sigedge,
    output logic ev
);

    localparam int unsigned CNT_W    = (FILT == 0) ? 1 : $clog2(FILT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((FILT == 0) ? 0 : FILT - 1);

    logic             s;
    logic             flt;
    logic             primed;
    logic             chg;
    logic [CNT_W-1:0] cnt;

    generate
        if (SYNC != 0) begin : g_sync
            logic [1:0] sync_r;
            always_ff @(posedge clk) begin
                if (rst) sync_r <= '0;
                else     sync_r <= {sync_r[0], sigedge};
            end
            assign s = sync_r[1];
        end else begin : g_nosync
            assign s = sigedge;
        end
    endgenerate

    // A change is accepted once it has persisted for FILT samples (immediately when FILT is 0).
    always_comb begin
        chg = 1'b0;
        if (primed && (s != flt) && ((FILT == 0) || (cnt == CNT_LAST))) chg = 1'b1;
    end

    // The first cycle after reset adopts the current level so reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            primed <= 1'b0;
            flt    <= 1'b0;
            cnt    <= '0;
        end else if (!primed) begin
            primed <= 1'b1;
            flt    <= s;
            cnt    <= '0;
        end else if (s == flt) begin
            cnt    <= '0;
        end else if (chg) begin
            flt    <= s;
            cnt    <= '0;
        end else begin
            cnt    <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        ev = 1'b0;
        case (MODE)
            EDGE_RISE:  ev = chg & s;
            EDGE_FALL:  ev = chg & ~s;
            EDGE_BOTH:  ev = chg;
            EDGE_LEVEL: ev = flt;
            default:    ev = 1'b0;
        endcase
    end

endmodule

// File: rtl/jtframe_edge_irq.sv
// W-channel edge-capture bank with pending/overflow flags and a lowest-index interrupt request.
module jtframe_edge_irq
    import jtframe_edge_pkg::*;
#(
    parameter int unsigned     W    = 8,
    parameter logic [2*W-1:0]  MODE = '0,
    parameter int unsigned     SYNC = 1,
    parameter int unsigned     FILT = 0
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic [W-1:0]    din,
    input  logic [W-1:0]    sigedge,
    input  logic [W-1:0]    set,
    input  logic [W-1:0]    clr,
    input  logic [W-1:0]    ack,
    output logic [W-1:0]    q,
    output logic [W-1:0]    qn,
    output logic [W-1:0]    pend,
    output logic [W-1:0]    ovf,
    output logic            irq,
    output logic [ID_W-1:0] irq_id
);

    logic [W-1:0] ev;
    logic [W-1:0] q_nxt;
    logic [W-1:0] pend_nxt;
    logic [W-1:0] ovf_nxt;

    generate
        for (genvar gi = 0; gi < int'(W); gi++) begin : g_ch
            jtframe_edge_det #(
                .MODE (MODE[2*gi +: 2]),
                .SYNC (SYNC),
                .FILT (FILT)
            ) u_det (
                .clk     (clk),
                .rst     (rst),
                .sigedge (sigedge[gi]),
                .ev      (ev[gi])
            );
        end
    endgenerate

    // clr beats set beats capture; an event still marks pending even when its capture is overridden.
    always_comb begin
        q_nxt    = q;
        pend_nxt = pend;
        ovf_nxt  = ovf;
        for (int i = 0; i < int'(W); i++) begin
            if (cen && clr[i])      q_nxt[i] = 1'b0;
            else if (cen && set[i]) q_nxt[i] = 1'b1;
            else if (ev[i])         q_nxt[i] = din[i];

            if (ev[i]) begin
                pend_nxt[i] = 1'b1;
                if (ack[i])       ovf_nxt[i] = 1'b0;
                else if (pend[i]) ovf_nxt[i] = 1'b1;
            end else if (ack[i]) begin
                pend_nxt[i] = 1'b0;
                ovf_nxt[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q      <= '0;
            qn     <= '1;
            pend   <= '0;
            ovf    <= '0;
            irq    <= 1'b0;
            irq_id <= '0;
        end else begin
            q      <= q_nxt;
            qn     <= ~q_nxt;
            pend   <= pend_nxt;
            ovf    <= ovf_nxt;
            irq    <= |pend;
            irq_id <= lowest_set(MAX_CH'(pend));
        end
    end

endmodule

// File: tb/tb_jtframe_edge_irq.sv
// Bench for jtframe_edge_irq: two configurations driven in parallel and checked against a history-based model.
module tb_jtframe_edge_irq;

    localparam int unsigned W      = 4;
    localparam logic [7:0]  MODE_A = 8'b10_00_01_01;  // ch3 both, ch2 rise, ch1 fall, ch0 fall
    localparam logic [7:0]  MODE_B = 8'b10_10_11_00;  // ch3 both, ch2 both, ch1 level, ch0 rise

    logic         clk = 1'b0;
    logic         rst, cen;
    logic [W-1:0] din, sigedge, set, clr, ack;

    logic [W-1:0] q_a, qn_a, pend_a, ovf_a;
    logic         irq_a;
    logic [4:0]   id_a;
    logic [W-1:0] q_b, qn_b, pend_b, ovf_b;
    logic         irq_b;
    logic [4:0]   id_b;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    jtframe_edge_irq #(.W(W), .MODE(MODE_A), .SYNC(0), .FILT(0)) u_dut_a (
        .clk(clk), .rst(rst), .cen(cen), .din(din), .sigedge(sigedge), .set(set),
        .clr(clr), .ack(ack), .q(q_a), .qn(qn_a), .pend(pend_a), .ovf(ovf_a),
        .irq(irq_a), .irq_id(id_a)
    );

    jtframe_edge_irq #(.W(W), .MODE(MODE_B), .SYNC(1), .FILT(3)) u_dut_b (
        .clk(clk), .rst(rst), .cen(cen), .din(din), .sigedge(sigedge), .set(set),
        .clr(clr), .ack(ack), .q(q_b), .qn(qn_b), .pend(pend_b), .ovf(ovf_b),
        .irq(irq_b), .irq_id(id_b)
    );

    // Reference model: raw input history since reset, accepted level per channel and event bookkeeping.
    logic [W-1:0] hist[$];
    logic [W-1:0] acc[2];
    logic [W-1:0] m_q[2], m_pend[2], m_ovf[2];
    logic         m_irq[2];
    logic [4:0]   m_id[2];
    int           last[2][W];

    function automatic logic [1:0] mode_of(input int d, input int ch);
        logic [7:0] mv;
        mv = (d == 0) ? MODE_A : MODE_B;
        return mv[2*ch +: 2];
    endfunction

    function automatic int filt_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Sample seen by the detector at edge k; the synchronized copy lags two edges and starts at 0.
    function automatic logic s_at(input int d, input int k, input int ch);
        logic [W-1:0] v;
        if (d == 1) begin
            if (k < 2) return 1'b0;
            v = hist[k-2];
        end else begin
            v = hist[k];
        end
        return v[ch];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int           t, fe;
        logic         s, old, ok, chg, e;
        logic [W-1:0] pold;
        if (rst) begin
            hist.delete();
            for (int d = 0; d < 2; d++) begin
                acc[d] = '0; m_q[d] = '0; m_pend[d] = '0; m_ovf[d] = '0;
                m_irq[d] = 1'b0; m_id[d] = '0;
                for (int ch = 0; ch < W; ch++) last[d][ch] = 0;
            end
            return;
        end
        hist.push_back(sigedge);
        t = hist.size() - 1;
        for (int d = 0; d < 2; d++) begin
            pold = m_pend[d];
            for (int ch = 0; ch < W; ch++) begin
                old = acc[d][ch];
                s   = s_at(d, t, ch);
                chg = 1'b0;
                if (t == 0) begin
                    acc[d][ch]  = s;
                    last[d][ch] = 0;
                end else begin
                    fe = (filt_of(d) == 0) ? 1 : filt_of(d);
                    ok = 1'b1;
                    for (int k = t - fe + 1; k <= t; k++)
                        if (k <= last[d][ch] || s_at(d, k, ch) == old) ok = 1'b0;
                    if (ok) begin
                        chg = 1'b1;
                        acc[d][ch]  = ~old;
                        last[d][ch] = t;
                    end
                end
                case (mode_of(d, ch))
                    2'd0:    e = chg && acc[d][ch];
                    2'd1:    e = chg && !acc[d][ch];
                    2'd2:    e = chg;
                    default: e = old;
                endcase
                if (cen && clr[ch])      m_q[d][ch] = 1'b0;
                else if (cen && set[ch]) m_q[d][ch] = 1'b1;
                else if (e)              m_q[d][ch] = din[ch];
                if (e) begin
                    if (ack[ch])             m_ovf[d][ch] = 1'b0;
                    else if (m_pend[d][ch])  m_ovf[d][ch] = 1'b1;
                    m_pend[d][ch] = 1'b1;
                end else if (ack[ch]) begin
                    m_pend[d][ch] = 1'b0;
                    m_ovf[d][ch]  = 1'b0;
                end
            end
            m_irq[d] = |pold;
            m_id[d]  = '0;
            for (int i = W - 1; i >= 0; i--) if (pold[i]) m_id[d] = 5'(i);
        end
    endtask

    task automatic check_all();
        logic [W-1:0] nq0, nq1;
        nq0 = ~m_q[0];
        nq1 = ~m_q[1];
        check("q_a",    32'(q_a),    32'(m_q[0]));
        check("qn_a",   32'(qn_a),   32'(nq0));
        check("pend_a", 32'(pend_a), 32'(m_pend[0]));
        check("ovf_a",  32'(ovf_a),  32'(m_ovf[0]));
        check("irq_a",  32'(irq_a),  32'(m_irq[0]));
        check("id_a",   32'(id_a),   32'(m_id[0]));
        check("q_b",    32'(q_b),    32'(m_q[1]));
        check("qn_b",   32'(qn_b),   32'(nq1));
        check("pend_b", 32'(pend_b), 32'(m_pend[1]));
        check("ovf_b",  32'(ovf_b),  32'(m_ovf[1]));
        check("irq_b",  32'(irq_b),  32'(m_irq[1]));
        check("id_b",   32'(id_b),   32'(m_id[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset(input logic [W-1:0] sig_hold);
        rst = 1'b1; cen = 1'b0; set = '0; clr = '0; ack = '0; sigedge = sig_hold;
        step(); step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; din = '0; sigedge = '0; set = '0; clr = '0; ack = '0;

        // Reset values and a rising edge on channel 2 of the unsynchronized bank
        do_reset(4'h0);
        check("rst_qn_a", 32'(qn_a), 32'hF);
        check("rst_irq_a", 32'(irq_a), 32'h0);
        din = 4'b0100;
        repeat (5) step();
        sigedge = 4'b0100;
        step();
        check("s1_q2", 32'(q_a[2]), 32'h1);
        check("s1_pend", 32'(pend_a), 32'h4);
        check("s1_irq_early", 32'(irq_a), 32'h0);
        step();
        check("s1_irq", 32'(irq_a), 32'h1);
        check("s1_id", 32'(id_a), 32'h2);

        // Glitch filter on the synchronized bank
        do_reset(4'h0);
        repeat (4) step();
        sigedge = 4'b0001; step(); step();
        sigedge = 4'b0000;
        repeat (8) step();
        check("s2_pulse", 32'(pend_b[0]), 32'h0);
        sigedge = 4'b0001;
        repeat (4) step();
        check("s2_before", 32'(pend_b[0]), 32'h0);
        sigedge = 4'b0000;
        step();
        check("s2_after", 32'(pend_b[0]), 32'h1);

        // Fall vs both-edge channels and overflow clear by ack
        do_reset(4'b1010);
        repeat (3) step();
        sigedge = 4'b0000; step();
        sigedge = 4'b1010; step();
        check("s3_pend1", 32'(pend_a[1]), 32'h1);
        check("s3_ovf1", 32'(ovf_a[1]), 32'h0);
        check("s3_ovf3", 32'(ovf_a[3]), 32'h1);
        ack = 4'b1000; step(); ack = '0;
        check("s3_pend3", 32'(pend_a[3]), 32'h0);
        check("s3_ovf3c", 32'(ovf_a[3]), 32'h0);

        // clr overrides capture but the event still pends; set ignored without cen
        do_reset(4'b0001);
        din = 4'b0001;
        repeat (3) step();
        cen = 1'b1; clr = 4'b0001; sigedge = 4'b0000; step();
        check("s4_q0", 32'(q_a[0]), 32'h0);
        check("s4_qn0", 32'(qn_a[0]), 32'h1);
        check("s4_pend0", 32'(pend_a[0]), 32'h1);
        cen = 1'b0; clr = '0; set = 4'b0001; step();
        check("s4_nocen", 32'(q_a[0]), 32'h0);
        cen = 1'b1; step();
        check("s4_set", 32'(q_a[0]), 32'h1);
        cen = 1'b0; set = '0;

        // No spurious edge after reset; priority between two pending channels
        do_reset(4'hF);
        repeat (6) step();
        check("s5_quiet", 32'(pend_a), 32'h0);
        sigedge = 4'b1110; step();
        check("s5_pend0", 32'(pend_a[0]), 32'h1);
        step();
        check("s5_id0", 32'(id_a), 32'h0);
        sigedge = 4'b1010; step();
        sigedge = 4'b1110; step();
        check("s5_both", 32'(pend_a), 32'h5);
        step();
        check("s5_id_both", 32'(id_a), 32'h0);
        ack = 4'b0001; step(); ack = '0;
        check("s5_ack", 32'(pend_a), 32'h4);
        check("s5_id_lag", 32'(id_a), 32'h0);
        step();
        check("s5_id2", 32'(id_a), 32'h2);

        // Randomized traffic, occasional mid-stream resets
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            din = W'($urandom);
            cen = 1'($urandom_range(0, 1));
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 3) == 0) sigedge[i] = ~sigedge[i];
                set[i] = ($urandom_range(0, 7) == 0);
                clr[i] = ($urandom_range(0, 7) == 0);
                ack[i] = ($urandom_range(0, 5) == 0);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
